sqrt_uns_seq: RTL

- Sequential unsigned integer square-root unit; the inverse companion to the unsigned squarer datapath.
- Computes Q = floor(sqrt(X)) and R = X - Q*Q using restoring digit recurrence, one result bit per cycle.
- Valid/ready handshake on both sides; one operation in flight.
- Sits beside the squarer in the arithmetic library for normalisation and distance datapaths.

---
 rtl/sqrt_uns_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sqrt_uns_seq.sv
// sqrt_uns_seq: sequential unsigned integer square root.
//
// Computes Q = floor(sqrt(X)) and R = X - Q*Q by restoring digit recurrence.
// One operation is in flight at a time, with a valid/ready handshake on each side.
//
// Build option:
//   SQRT_UNS_RADIX4_EN - when defined, two root bits are retired per cycle
//                        (width must be a multiple of 4). Results are identical;
//                        only the latency halves.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand valid
//   in_ready_o   unit idle and able to accept an operand (decoded from state only)
//   X_i          unsigned radicand, width bits
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   Q_o          root, width/2 bits
//   R_o          remainder, width/2+1 bits (at most 2Q)
module sqrt_uns_seq #(
  parameter int width = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [width-1:0]   X_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [width/2-1:0] Q_o,
  output logic [width/2:0]   R_o
);

  localparam int H = width / 2;
`ifdef SQRT_UNS_RADIX4_EN
  localparam int ITERS = width / 4;
`else
  localparam int ITERS = H;
`endif
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

  if ((width % 2) != 0 || width < 4) begin : g_bad_width
    $error("sqrt_uns_seq: width must be even and >= 4");
  end
`ifdef SQRT_UNS_RADIX4_EN
  if ((width % 4) != 0) begin : g_bad_width_r4
    $error("sqrt_uns_seq: width must be a multiple of 4 in radix-4 mode");
  end
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] x_q, x_d;
  logic [H-1:0]     q_q, q_d;
  logic [H:0]       r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One restoring iteration; result packed as {q_new, r_new}.
  // Before any iteration the partial root has at most H-1 significant bits
  // and r <= 2q < 2^H, so r' = 4r+3 fits in H+2 bits and r'-t fits in H+1.
  function automatic logic [2*H:0] sqrt_step(input logic [H-1:0] q,
                                             input logic [H:0]   r,
                                             input logic [1:0]   bits);
    logic [H+2:0] r_sh;
    logic [H+2:0] t;
    logic [H:0]   r_new;
    logic [H-1:0] q_new;
    r_sh = {r, bits};
    t    = {1'b0, q, 2'b01};
    if (r_sh >= t) begin
      r_new = r_sh[H:0] - t[H:0];
      q_new = {q[H-2:0], 1'b1};
    end else begin
      r_new = r_sh[H:0];
      q_new = {q[H-2:0], 1'b0};
    end
    return {q_new, r_new};
  endfunction

  logic [2*H:0] step1;
`ifdef SQRT_UNS_RADIX4_EN
  logic [2*H:0] step2;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    step1   = sqrt_step(q_q, r_q, x_q[width-1 -: 2]);
`ifdef SQRT_UNS_RADIX4_EN
    step2   = sqrt_step(step1[2*H:H+1], step1[H:0], x_q[width-3 -: 2]);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          x_d     = X_i;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef SQRT_UNS_RADIX4_EN
        {q_d, r_d} = step2;
        x_d        = {x_q[width-5:0], 4'b0000};
`else
        {q_d, r_d} = step1;
        x_d        = {x_q[width-3:0], 2'b00};
`endif
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: FSM state, operand shift register, partial root/remainder.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign Q_o         = q_q;
  assign R_o         = r_q;

endmodule
